instr_fetch: RTL and testbench

- Instruction fetch unit directly upstream of the multicycle controller.
- On each controller INSTR_REQ, issues a read to instruction memory via a req/ack handshake, latches the returned word and pulses INSTR_VALID.
- Maintains the PC: sequential PC+4, or the branch target when BRANCH is high.
- Supplies the held instruction word and its 7-bit opcode (INSTR) to the controller.

---
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches one word from instruction memory per INSTR_REQ
// over a req/ack handshake, keeps the PC and presents the held word and opcode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        INSTR_REQ,
    input  logic        BRANCH,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_RDATA,
    input  logic        IMEM_ACK,
    output logic [31:0] INSTR_WORD,
    output logic [6:0]  INSTR,
    output logic        INSTR_VALID,
    output logic [31:0] PC,
    output logic        FETCH_ERR
);

    localparam logic [31:0] NOP_WORD      = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        ERROR
    } state_t;

    state_t      state_reg;
    logic        imem_req_reg;
    logic [31:0] imem_addr_reg;
    logic [31:0] instr_word_reg;
    logic        instr_valid_reg;
    logic [31:0] pc_reg;
    logic        fetch_err_reg;
    logic        first_fetch_reg;
    logic [7:0]  timeout_cnt_reg;

    logic [31:0] fetch_addr_next;
    logic [7:0]  timeout_cnt_next;

    // Branch wins over the post-reset first fetch; sequential fetch wraps mod 2^32.
    always_comb begin
        fetch_addr_next = pc_reg + 32'd4;
        if (BRANCH) begin
            fetch_addr_next = BRANCH_TARGET & 32'hFFFF_FFFC;
        end else if (first_fetch_reg) begin
            fetch_addr_next = RESET_PC;
        end
    end

    assign timeout_cnt_next = timeout_cnt_reg + 8'd1;

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_reg       <= IDLE;
            imem_req_reg    <= 1'b0;
            imem_addr_reg   <= 32'h0000_0000;
            instr_word_reg  <= NOP_WORD;
            instr_valid_reg <= 1'b0;
            pc_reg          <= RESET_PC;
            fetch_err_reg   <= 1'b0;
            first_fetch_reg <= 1'b1;
            timeout_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    instr_valid_reg <= 1'b0;
                    if (INSTR_REQ) begin
                        state_reg       <= REQ;
                        imem_req_reg    <= 1'b1;
                        imem_addr_reg   <= fetch_addr_next;
                        first_fetch_reg <= 1'b0;
                        timeout_cnt_reg <= 8'd0;
                    end
                end
                REQ: begin
                    if (IMEM_ACK) begin
                        state_reg       <= DONE;
                        instr_word_reg  <= IMEM_RDATA;
                        pc_reg          <= imem_addr_reg;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_next;
                        if (timeout_cnt_next == TIMEOUT_LIMIT) begin
                            state_reg     <= ERROR;
                            imem_req_reg  <= 1'b0;
                            fetch_err_reg <= 1'b1;
                        end
                    end
                end
                // The controller is still holding INSTR_REQ here; it must not start a second fetch.
                DONE: begin
                    instr_valid_reg <= 1'b0;
                    state_reg       <= IDLE;
                end
                ERROR: begin
                    imem_req_reg    <= 1'b0;
                    instr_valid_reg <= 1'b0;
                    fetch_err_reg   <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign IMEM_REQ    = imem_req_reg;
    assign IMEM_ADDR   = imem_addr_reg;
    assign INSTR_WORD  = instr_word_reg;
    assign INSTR       = instr_word_reg[6:0];
    assign INSTR_VALID = instr_valid_reg;
    assign PC          = pc_reg;
    assign FETCH_ERR   = fetch_err_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized fetches,
// each checked against a PC/first-fetch/held-word model of the fetch rules.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC       = 32'h0000_0000;
    localparam int          TIMEOUT_CYCLES = 16;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0013;

    logic        CLK;
    logic        RES;
    logic        INSTR_REQ;
    logic        BRANCH;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA;
    logic        IMEM_ACK;
    logic [31:0] INSTR_WORD;
    logic [6:0]  INSTR;
    logic        INSTR_VALID;
    logic [31:0] PC;
    logic        FETCH_ERR;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_word;
    logic        m_first;

    instr_fetch #(
        .RESET_PC      (RESET_PC),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK          (CLK),
        .RES          (RES),
        .INSTR_REQ    (INSTR_REQ),
        .BRANCH       (BRANCH),
        .BRANCH_TARGET(BRANCH_TARGET),
        .IMEM_REQ     (IMEM_REQ),
        .IMEM_ADDR    (IMEM_ADDR),
        .IMEM_RDATA   (IMEM_RDATA),
        .IMEM_ACK     (IMEM_ACK),
        .INSTR_WORD   (INSTR_WORD),
        .INSTR        (INSTR),
        .INSTR_VALID  (INSTR_VALID),
        .PC           (PC),
        .FETCH_ERR    (FETCH_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_word  = NOP_WORD;
        m_first = 1'b1;
    endtask

    // One complete fetch: request, `waits` cycles without ack, ack, DONE, back to idle.
    task automatic fetch(input logic b, input logic [31:0] t, input int waits, input logic [31:0] d);
        logic [31:0] a;
        if (b)
            a = t & 32'hFFFF_FFFC;
        else if (m_first)
            a = RESET_PC;
        else
            a = m_pc + 32'd4;
        INSTR_REQ = 1'b1; BRANCH = b; BRANCH_TARGET = t; IMEM_ACK = 1'b0;
        tick();
        m_first = 1'b0;
        check("req_rise", {31'd0, IMEM_REQ}, 32'd1);
        check("fetch_addr", IMEM_ADDR, a);
        check("valid_at_req", {31'd0, INSTR_VALID}, 32'd0);
        BRANCH = 1'($urandom_range(0, 1));
        BRANCH_TARGET = $urandom;
        for (int w = 0; w < waits; w++) begin
            tick();
            check("req_wait", {31'd0, IMEM_REQ}, 32'd1);
            check("addr_hold", IMEM_ADDR, a);
            check("valid_wait", {31'd0, INSTR_VALID}, 32'd0);
            check("word_hold_wait", INSTR_WORD, m_word);
        end
        IMEM_ACK = 1'b1; IMEM_RDATA = d;
        tick();
        m_word = d;
        m_pc   = a;
        check("valid_pulse", {31'd0, INSTR_VALID}, 32'd1);
        check("instr_word", INSTR_WORD, m_word);
        check("opcode", {25'd0, INSTR}, {25'd0, d[6:0]});
        check("pc", PC, m_pc);
        check("req_drop", {31'd0, IMEM_REQ}, 32'd0);
        IMEM_ACK = 1'($urandom_range(0, 1));
        IMEM_RDATA = $urandom;
        tick();
        check("valid_one_cycle", {31'd0, INSTR_VALID}, 32'd0);
        check("no_refetch_done", {31'd0, IMEM_REQ}, 32'd0);
        check("word_after_done", INSTR_WORD, m_word);
        INSTR_REQ = 1'b0; IMEM_ACK = 1'b0; BRANCH = 1'b0;
        tick();
        check("idle_after_done", {31'd0, IMEM_REQ}, 32'd0);
        check("pc_stable", PC, m_pc);
    endtask

    // Idle cycles with noise on ack/rdata/branch; nothing may change.
    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            INSTR_REQ = 1'b0;
            BRANCH = 1'($urandom_range(0, 1));
            BRANCH_TARGET = $urandom;
            IMEM_ACK = 1'($urandom_range(0, 1));
            IMEM_RDATA = $urandom;
            tick();
            check("idle_req", {31'd0, IMEM_REQ}, 32'd0);
            check("idle_valid", {31'd0, INSTR_VALID}, 32'd0);
            check("idle_word", INSTR_WORD, m_word);
            check("idle_pc", PC, m_pc);
        end
        IMEM_ACK = 1'b0; BRANCH = 1'b0;
    endtask

    task automatic do_reset();
        RES = 1'b1; INSTR_REQ = 1'b0; BRANCH = 1'b0; IMEM_ACK = 1'b0;
        tick();
        tick();
        RES = 1'b0;
        model_reset();
    endtask

    initial begin
        RES = 1'b1; INSTR_REQ = 1'b0; BRANCH = 1'b0; BRANCH_TARGET = 32'd0;
        IMEM_ACK = 1'b0; IMEM_RDATA = 32'd0;
        model_reset();
        tick();
        tick();
        check("rst_imem_req", {31'd0, IMEM_REQ}, 32'd0);
        check("rst_imem_addr", IMEM_ADDR, 32'd0);
        check("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
        check("rst_err", {31'd0, FETCH_ERR}, 32'd0);
        check("rst_word", INSTR_WORD, NOP_WORD);
        check("rst_opcode", {25'd0, INSTR}, 32'h13);
        check("rst_pc", PC, RESET_PC);
        RES = 1'b0;
        idle_noise(2);

        // First fetch after reset, zero-wait, then sequential with 3 wait states.
        fetch(1'b0, 32'd0, 0, 32'h0000_0033);
        fetch(1'b0, 32'd0, 3, 32'h0000_0013);

        // Misaligned branch target, then sequential from it.
        fetch(1'b1, 32'h0000_0103, 0, 32'h0000_006F);
        fetch(1'b0, 32'd0, 1, 32'h0000_0063);

        // PC wrap at the top of the address space.
        fetch(1'b1, 32'hFFFF_FFFF, 2, 32'h0000_0003);
        fetch(1'b0, 32'd0, 0, 32'h0000_0023);

        // Timeout: ack never comes.
        INSTR_REQ = 1'b1; BRANCH = 1'b0; IMEM_ACK = 1'b0;
        tick();
        check("to_req_rise", {31'd0, IMEM_REQ}, 32'd1);
        check("to_addr", IMEM_ADDR, m_pc + 32'd4);
        for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
            tick();
            check("to_req", {31'd0, IMEM_REQ}, (i < TIMEOUT_CYCLES) ? 32'd1 : 32'd0);
            check("to_err", {31'd0, FETCH_ERR}, (i < TIMEOUT_CYCLES) ? 32'd0 : 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            INSTR_REQ = 1'b1; IMEM_ACK = 1'b1; IMEM_RDATA = $urandom;
            tick();
            check("err_sticky", {31'd0, FETCH_ERR}, 32'd1);
            check("err_no_req", {31'd0, IMEM_REQ}, 32'd0);
            check("err_no_valid", {31'd0, INSTR_VALID}, 32'd0);
            check("err_word", INSTR_WORD, m_word);
            check("err_pc", PC, m_pc);
        end
        do_reset();
        check("err_cleared", {31'd0, FETCH_ERR}, 32'd0);

        // Branch takes priority over the post-reset first fetch.
        fetch(1'b1, 32'h0000_0202, 0, 32'h0000_0037);
        fetch(1'b0, 32'd0, 0, 32'h0000_0017);

        // Reset in REQ together with an ack: the ack is discarded.
        INSTR_REQ = 1'b1; BRANCH = 1'b0; IMEM_ACK = 1'b0;
        tick();
        check("mid_req", {31'd0, IMEM_REQ}, 32'd1);
        INSTR_REQ = 1'b0; RES = 1'b1; IMEM_ACK = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF;
        tick();
        RES = 1'b0; IMEM_ACK = 1'b0;
        model_reset();
        check("abort_req", {31'd0, IMEM_REQ}, 32'd0);
        check("abort_valid", {31'd0, INSTR_VALID}, 32'd0);
        check("abort_word", INSTR_WORD, NOP_WORD);
        check("abort_pc", PC, RESET_PC);
        tick();
        check("abort_idle", {31'd0, IMEM_REQ}, 32'd0);
        fetch(1'b0, 32'd0, 0, 32'h0000_0073);

        // Randomized fetch traffic.
        for (int n = 0; n < 40; n++) begin
            idle_noise(int'($urandom_range(0, 2)));
            fetch(($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 6)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
